// File: rtl/lsu_controller_pkg.sv
// Shared types for the load/store unit: memory-op encoding, FSM states and size codes.
// Op encoding is {store, unsigned, size[1:0]}; size 2'b11 is reserved for MEM_NOP.
package core;

   localparam int unsigned MEM_OP_BITS = 4;
   localparam logic        STORE_PRFX  = 1'b1;

   localparam logic [1:0] MEM_SZ_B = 2'b00;
   localparam logic [1:0] MEM_SZ_H = 2'b01;
   localparam logic [1:0] MEM_SZ_W = 2'b10;

   typedef enum logic [MEM_OP_BITS-1:0] {
      LB      = 4'b0000,
      LH      = 4'b0001,
      LW      = 4'b0010,
      MEM_NOP = 4'b0011,
      LBU     = 4'b0100,
      LHU     = 4'b0101,
      SB      = 4'b1000,
      SH      = 4'b1001,
      SW      = 4'b1010
   } mem_op_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

   function automatic logic is_store(mem_op_t op);
      return op[MEM_OP_BITS-1] == STORE_PRFX;
   endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Data-memory port: req/gnt/rvalid handshake with byte-enabled word writes.
interface lsu_controller_if;

   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/lsu_controller_align.sv
// Combinational lane logic: byte enables, store replication, load extraction, alignment check.
module lsu_align
   import core::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [31:0] rdata_sh;

   assign rdata_sh = rdata >> {addr_lo, 3'b000};

   always_comb begin
      be         = '0;
      wdata_sh   = wdata;
      rdata_ext  = rdata;
      misaligned = 1'b0;
      case (op[1:0])
         MEM_SZ_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_sh  = {4{wdata[7:0]}};
            rdata_ext = op[2] ? {24'h0, rdata_sh[7:0]} : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
         end
         MEM_SZ_H: begin
            be         = 4'b0011 << addr_lo;
            wdata_sh   = {2{wdata[15:0]}};
            rdata_ext  = op[2] ? {16'h0, rdata_sh[15:0]} : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            misaligned = addr_lo[0];
         end
         MEM_SZ_W: begin
            be         = '1;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: one access per instruction, stalls the pipeline while outstanding,
// aborts on bus timeout and rejects misaligned accesses.
module lsu_controller
   import core::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   input  mem_op_t           mem_op_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              stall_o,
   output logic              ld_valid_o,
   output logic [31:0]       ld_data_o,
   output logic              misalign_o,
   output logic              timeout_o,
   lsu_controller_if.master  dmem
);

   lsu_state_t       state;
   mem_op_t          op_q;
   logic [1:0]       addr_lo_q;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             last_cycle;
   mem_op_t          align_op;
   logic [1:0]       align_lo;
   logic [3:0]       be;
   logic [31:0]      wdata_sh;
   logic [31:0]      rdata_ext;
   logic             misaligned;

   assign accept     = (state == IDLE) && req_valid_i && (mem_op_i != MEM_NOP);
   assign last_cycle = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // One lane unit serves both directions: inputs drive it at accept, latched op afterwards.
   assign align_op = (state == IDLE) ? mem_op_i : op_q;
   assign align_lo = (state == IDLE) ? addr_i[1:0] : addr_lo_q;

   assign stall_o = (accept && !misaligned) || (state == REQ) || (state == WAIT);

   lsu_align u_align (
      .op         (align_op),
      .addr_lo    (align_lo),
      .wdata      (wdata_i),
      .rdata      (dmem.rdata),
      .be         (be),
      .wdata_sh   (wdata_sh),
      .rdata_ext  (rdata_ext),
      .misaligned (misaligned)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         op_q       <= MEM_NOP;
         addr_lo_q  <= '0;
         cnt        <= '0;
         ld_valid_o <= 1'b0;
         ld_data_o  <= '0;
         misalign_o <= 1'b0;
         timeout_o  <= 1'b0;
         dmem.req   <= 1'b0;
         dmem.we    <= 1'b0;
         dmem.be    <= '0;
         dmem.addr  <= '0;
         dmem.wdata <= '0;
      end else begin
         ld_valid_o <= 1'b0;
         misalign_o <= 1'b0;
         timeout_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (misaligned) begin
                     misalign_o <= 1'b1;
                  end else begin
                     op_q       <= mem_op_i;
                     addr_lo_q  <= addr_i[1:0];
                     cnt        <= '0;
                     dmem.req   <= 1'b1;
                     dmem.we    <= is_store(mem_op_i);
                     dmem.be    <= be;
                     dmem.addr  <= {addr_i[31:2], 2'b00};
                     dmem.wdata <= wdata_sh;
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem.gnt && (is_store(op_q) || dmem.rvalid)) begin
                  dmem.req <= 1'b0;
                  if (!is_store(op_q)) begin
                     ld_data_o  <= rdata_ext;
                     ld_valid_o <= 1'b1;
                  end
                  state <= DONE;
               end else if (last_cycle) begin
                  dmem.req  <= 1'b0;
                  timeout_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (dmem.gnt) begin
                     dmem.req <= 1'b0;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem.rvalid) begin
                  ld_data_o  <= rdata_ext;
                  ld_valid_o <= 1'b1;
                  state      <= DONE;
               end else if (last_cycle) begin
                  timeout_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller with hand-computed expectations.
module tb_lsu_controller;
   import core::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid;
   mem_op_t     mem_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall, ld_valid, misalign, timeout;
   logic [31:0] ld_data;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   lsu_controller_if dmem();

   always #5 clk = ~clk;

   lsu_controller #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .mem_op_i    (mem_op),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .stall_o     (stall),
      .ld_valid_o  (ld_valid),
      .ld_data_o   (ld_data),
      .misalign_o  (misalign),
      .timeout_o   (timeout),
      .dmem        (dmem)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; mem_op = MEM_NOP; addr = '0; wdata = '0;
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
      n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ld_valid: got %b want 0", ld_valid); end
      n_checks++; if (ld_data !== 32'h0) begin n_fail++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
      n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b want 0", misalign); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req: got %b want 0", dmem.req); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_store_sw();
      cyc();
      req_valid = 1'b1; mem_op = SW; addr = 32'h100; wdata = 32'hDEADBEEF; dmem.gnt = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_accept_stall: got %b want 1", stall); end
      cyc();
      req_valid = 1'b0; mem_op = MEM_NOP; #1;
      n_checks++; if (dmem.req !== 1'b1) begin n_fail++; $display("FAIL sw_req: got %b want 1", dmem.req); end
      n_checks++; if (dmem.we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", dmem.we); end
      n_checks++; if (dmem.be !== 4'hF) begin n_fail++; $display("FAIL sw_be: got %h want f", dmem.be); end
      n_checks++; if (dmem.addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", dmem.addr); end
      n_checks++; if (dmem.wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", dmem.wdata); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_req_stall: got %b want 1", stall); end
      cyc();
      dmem.gnt = 1'b0; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_done_stall: got %b want 0", stall); end
      n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL sw_no_ld_valid: got %b want 0", ld_valid); end
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL sw_req_drop: got %b want 0", dmem.req); end
      cyc();
   endtask

   task automatic test_store_lanes();
      // SB at byte 2: replicated byte, single lane enable
      req_valid = 1'b1; mem_op = SB; addr = 32'h102; wdata = 32'h12345678; dmem.gnt = 1'b1;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1; #1;
      n_checks++; if (dmem.be !== 4'b0100) begin n_fail++; $display("FAIL sb_be: got %b want 0100", dmem.be); end
      n_checks++; if (dmem.wdata !== 32'h78787878) begin n_fail++; $display("FAIL sb_wdata: got %h want 78787878", dmem.wdata); end
      n_checks++; if (dmem.addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h want 00000100", dmem.addr); end
      cyc();
      dmem.gnt = 1'b0;
      cyc();
      req_valid = 1'b1; mem_op = SH; addr = 32'h102; wdata = 32'hAAAA5678; dmem.gnt = 1'b1;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1; #1;
      n_checks++; if (dmem.be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", dmem.be); end
      n_checks++; if (dmem.wdata !== 32'h56785678) begin n_fail++; $display("FAIL sh_wdata: got %h want 56785678", dmem.wdata); end
      cyc();
      dmem.gnt = 1'b0;
      cyc();
   endtask

   task automatic test_load_lb();
      req_valid = 1'b1; mem_op = LB; addr = 32'h203;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1; #1;
      n_checks++; if (dmem.be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", dmem.be); end
      n_checks++; if (dmem.addr !== 32'h200) begin n_fail++; $display("FAIL lb_addr: got %h want 00000200", dmem.addr); end
      n_checks++; if (dmem.we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", dmem.we); end
      cyc();
      dmem.gnt = 1'b0; #1;
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL lb_wait_req: got %b want 0", dmem.req); end
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lb_wait_stall: got %b want 1", stall); end
      cyc();
      dmem.rvalid = 1'b1; dmem.rdata = 32'h80FF0000; #1;
      n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL lb_early_valid: got %b want 0", ld_valid); end
      cyc();
      dmem.rvalid = 1'b0; dmem.rdata = '0; #1;
      n_checks++; if (ld_valid !== 1'b1) begin n_fail++; $display("FAIL lb_ld_valid: got %b want 1", ld_valid); end
      n_checks++; if (ld_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_ld_data: got %h want ffffff80", ld_data); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lb_done_stall: got %b want 0", stall); end
      cyc();
      n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL lb_pulse_width: got %b want 0", ld_valid); end
      n_checks++; if (ld_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data_hold: got %h want ffffff80", ld_data); end
   endtask

   task automatic test_load_lhu();
      req_valid = 1'b1; mem_op = LHU; addr = 32'h202;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 32'hBEEF1234; #1;
      n_checks++; if (dmem.be !== 4'b1100) begin n_fail++; $display("FAIL lhu_be: got %b want 1100", dmem.be); end
      cyc();
      idle_inputs(); #1;
      n_checks++; if (ld_valid !== 1'b1) begin n_fail++; $display("FAIL lhu_ld_valid: got %b want 1", ld_valid); end
      n_checks++; if (ld_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_ld_data: got %h want 0000beef", ld_data); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lhu_done_stall: got %b want 0", stall); end
      cyc();
      // LH sign-extends the low half: 0x8001 -> 0xFFFF8001
      req_valid = 1'b1; mem_op = LH; addr = 32'h200;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 32'h7FFF8001;
      cyc();
      idle_inputs(); #1;
      n_checks++; if (ld_data !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_ld_data: got %h want ffff8001", ld_data); end
      cyc();
   endtask

   task automatic test_misalign();
      req_valid = 1'b1; mem_op = SH; addr = 32'h101; wdata = 32'h1234; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sh_mis_stall: got %b want 0", stall); end
      cyc();
      idle_inputs(); #1;
      n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL sh_mis_pulse: got %b want 1", misalign); end
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL sh_mis_req: got %b want 0", dmem.req); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sh_mis_stall2: got %b want 0", stall); end
      req_valid = 1'b1; mem_op = LW; addr = 32'h12;
      cyc();
      idle_inputs(); #1;
      n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL lw_mis_pulse: got %b want 1", misalign); end
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL lw_mis_req: got %b want 0", dmem.req); end
      cyc();
      n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_width: got %b want 0", misalign); end
   endtask

   task automatic test_timeout();
      int unsigned req_low = 0;
      int unsigned early_to = 0;
      req_valid = 1'b1; mem_op = LW; addr = 32'h10;
      for (int i = 0; i < 16; i++) begin
         cyc();
         idle_inputs(); #1;
         if (dmem.req !== 1'b1 || stall !== 1'b1) req_low++;
         if (timeout !== 1'b0) early_to++;
      end
      n_checks++; if (req_low != 0) begin n_fail++; $display("FAIL to_req_held: got %0d bad cycles want 0", req_low); end
      n_checks++; if (early_to != 0) begin n_fail++; $display("FAIL to_early: got %0d early pulses want 0", early_to); end
      cyc();
      n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", timeout); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %b want 0", stall); end
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b want 0", dmem.req); end
      n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL to_ld_valid: got %b want 0", ld_valid); end
      dmem.rvalid = 1'b1; dmem.rdata = 32'h11111111;
      cyc();
      dmem.rvalid = 1'b0; #1;
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
      n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL to_late_rvalid: got %b want 0", ld_valid); end
   endtask

   task automatic test_reset_mid();
      int unsigned spurious = 0;
      req_valid = 1'b1; mem_op = LW; addr = 32'h40;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1;
      cyc();
      dmem.gnt = 1'b0; #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rm_wait_stall: got %b want 1", stall); end
      #2;
      rst_n = 1'b0; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %b want 0", stall); end
      n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", dmem.req); end
      @(negedge clk);
      rst_n = 1'b1;
      dmem.rvalid = 1'b1; dmem.rdata = 32'h22222222;
      for (int i = 0; i < 3; i++) begin
         cyc();
         dmem.rvalid = 1'b0;
         if (ld_valid !== 1'b0 || stall !== 1'b0) spurious++;
      end
      n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL rm_post_rvalid: got %0d bad cycles want 0", spurious); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; mem_op = SW; addr = 32'h104; wdata = 32'h1; dmem.gnt = 1'b1;
      cyc();
      idle_inputs(); dmem.gnt = 1'b1;
      cyc();
      dmem.gnt = 1'b0;
      req_valid = 1'b1; mem_op = LW; addr = 32'h300; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_no_accept: got %b want 0", stall); end
      cyc();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_accept: got %b want 1", stall); end
      cyc();
      idle_inputs(); dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFEF00D; #1;
      n_checks++; if (dmem.addr !== 32'h300) begin n_fail++; $display("FAIL b2b_addr: got %h want 00000300", dmem.addr); end
      n_checks++; if (dmem.we !== 1'b0) begin n_fail++; $display("FAIL b2b_we: got %b want 0", dmem.we); end
      cyc();
      idle_inputs(); #1;
      n_checks++; if (ld_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ld_valid: got %b want 1", ld_valid); end
      n_checks++; if (ld_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_ld_data: got %h want cafef00d", ld_data); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_store_sw();
      test_store_lanes();
      test_load_lb();
      test_load_lhu();
      test_misalign();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
